// File: rtl/imem_program_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
package imem_program_loader_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;

  // Starting value of the running XOR checksum
  localparam logic [DEF_DATA_W-1:0] CKSUM_INIT = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // States in which a frame is being received
  function automatic logic is_busy(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_program_loader_if
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Stream source that also observes the memory write bus
  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // Loader side: consumes the stream and drives the memory write bus
  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/imem_program_loader_write_port.sv
// Registered instruction-memory write stage with its address counter.
module imem_program_loader_write_port
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  // One write pulse per accepted byte; address is base plus bytes already written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= ADDR_W'(BASE_ADDR);
      wr_data <= '0;
      count   <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
        wr_data <= data;
      end
      if (clear) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a framed program (length, bytes, XOR checksum) into instruction
// memory and holds the processor in reset until the load is verified.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  imem_program_loader_if.slave  bus,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W:0]       loaded_count
);

  // Wide enough to compare any length byte against DEPTH without truncation
  localparam int unsigned LEN_W = DATA_W + ADDR_W + 2;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] remaining;
  logic [DATA_W-1:0] remaining_next;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic              xfer_c;
  logic              clear_c;
  logic              accept_c;

  assign xfer_c = bus.s_valid & bus.s_ready;

  // Next-state, length counter and checksum update
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    acc_next       = acc;
    clear_c        = 1'b0;
    accept_c       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_LEN;
          clear_c    = 1'b1;
          acc_next   = DATA_W'(CKSUM_INIT);
        end
      end
      ST_LEN: begin
        if (xfer_c) begin
          remaining_next = bus.s_data;
          if ((bus.s_data == '0) || (LEN_W'(bus.s_data) > LEN_W'(DEPTH))) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer_c) begin
          accept_c       = 1'b1;
          acc_next       = acc ^ bus.s_data;
          remaining_next = remaining - DATA_W'(1);
          if (remaining == DATA_W'(1)) begin
            state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (xfer_c) begin
          state_next = (bus.s_data == acc) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      acc         <= DATA_W'(CKSUM_INIT);
      bus.s_ready <= 1'b0;
      busy        <= 1'b0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      acc         <= acc_next;
      bus.s_ready <= is_busy(state_next);
      busy        <= is_busy(state_next);
      cpu_reset   <= (state_next != ST_DONE);
      done        <= (state_next == ST_DONE);
      error       <= (state_next == ST_ERROR);
    end
  end

  imem_program_loader_write_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_write_port (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_c),
    .accept  (accept_c),
    .data    (bus.s_data),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .count   (loaded_count)
  );

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed frames plus random
// frames, compared against a frame-level model of the expected writes/status.
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int BASE  = 0;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    time        t;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] loaded_count;

  int  errors = 0;
  int  checks = 0;
  wr_t obs[$];

  imem_program_loader_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  imem_program_loader #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .loaded_count (loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every memory write together with the time it was observed
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) obs.push_back('{t: $time, a: bus.wr_addr, d: bus.wr_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offer one byte until accepted; returns the accepting clock edge time
  task automatic send_byte(input logic [7:0] b, output time t);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_offer", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    t = $time;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
  endtask

  // Run one framed load and compare everything against the frame-level model
  task automatic run_frame(input byte_q_t fr, input int gap, input bit mid_start, input string tag);
    int         len;
    int         need;
    bit         legal;
    bit         exp_done;
    logic [7:0] x;
    time        acc_t[$];
    time        t;

    len   = int'(fr[0]);
    legal = (len != 0) && (len <= DEPTH);
    need  = legal ? len + 2 : 1;
    x     = 8'h00;
    if (legal) for (int i = 1; i <= len; i++) x ^= fr[i];
    exp_done = legal && (fr[len+1] == x);

    obs.delete();
    pulse_start();
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_cpurst_start"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done_start"}, 32'(done), 32'd0);
    check({tag, "_cnt_start"}, 32'(loaded_count), 32'd0);

    for (int i = 0; i < need; i++) begin
      if (mid_start && i == 2) start = 1'b1;
      send_byte(fr[i], t);
      start = 1'b0;
      if (legal && i >= 1 && i <= len) acc_t.push_back(t);
      if (i < need - 1) repeat (gap) @(negedge clk);
      if (i < need - 1) check({tag, "_cpurst_load"}, 32'(cpu_reset), 32'd1);
    end

    // One cycle after the final accepted byte
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_s_ready_end"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_cpurst_end"}, 32'(cpu_reset), 32'(!exp_done));
    repeat (2) @(negedge clk);
    check({tag, "_cnt"}, 32'(loaded_count), 32'(legal ? len : 0));
    check({tag, "_nwrites"}, 32'(obs.size()), 32'(acc_t.size()));
    for (int k = 0; k < obs.size() && k < acc_t.size(); k++) begin
      check({tag, "_waddr"}, 32'(obs[k].a), 32'((BASE + k) % 256));
      check({tag, "_wdata"}, 32'(obs[k].d), 32'(fr[k+1]));
      check({tag, "_wtime"}, 32'(obs[k].t), 32'(acc_t[k] + 5));
    end
  endtask

  initial begin
    byte_q_t fr;
    time     t;
    int      len;
    logic [7:0] x;

    reset       = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    #2;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'(BASE));
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cnt", 32'(loaded_count), 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 32'(bus.s_ready), 32'd0);

    fr = '{8'h03, 8'h41, 8'h82, 8'hC7, 8'h04};
    run_frame(fr, 0, 1'b0, "normal");

    fr = '{8'h01, 8'h99, 8'h99};
    run_frame(fr, 0, 1'b1, "restart");

    fr = '{8'h03, 8'h41, 8'h82, 8'hC7, 8'h05};
    run_frame(fr, 0, 1'b0, "badsum");

    fr = '{8'h00};
    run_frame(fr, 0, 1'b0, "zerolen");

    fr = '{8'h02, 8'h10, 8'h20, 8'h30};
    run_frame(fr, 3, 1'b0, "backpress");

    fr = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01};
    run_frame(fr, 0, 1'b1, "midstart");

    // Reset in the middle of a length-4 load, after the second data byte
    obs.delete();
    pulse_start();
    send_byte(8'h04, t);
    send_byte(8'h11, t);
    send_byte(8'h22, t);
    #2 reset = 1'b1;
    #1;
    check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_cnt", 32'(loaded_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    fr = '{8'h02, 8'h5A, 8'hA5, 8'hFF};
    run_frame(fr, 1, 1'b0, "after_rst");

    // Random frames with random gaps and occasionally corrupted checksums
    for (int n = 0; n < 12; n++) begin
      len = $urandom_range(1, 10);
      fr.delete();
      fr.push_back(8'(len));
      x = 8'h00;
      for (int i = 0; i < len; i++) begin
        fr.push_back(8'($urandom));
        x ^= fr[i+1];
      end
      if ($urandom_range(0, 2) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      fr.push_back(x);
      run_frame(fr, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface; the pipelined processor's fetch stage is the reader.
- Accepts a framed byte stream over a valid/ready handshake: length byte, N instruction bytes, then an XOR checksum byte.
- Writes the instruction bytes into instruction memory starting at BASE_ADDR.
- Holds the processor in reset (cpu_reset) until the program is loaded and the checksum verified.

Parameters:
- DATA_W, 8, instruction/byte width.
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, instruction memory words; legal length is 1..DEPTH.
- BASE_ADDR, 0, first write address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- s_valid  in  1  stream byte valid.
- s_data  in  DATA_W  stream byte.
- s_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  instruction memory write address.
- wr_data  out  DATA_W  instruction memory write data.
- cpu_reset  out  1  hold processor in reset while high.
- busy  out  1  load in progress (states LEN, DATA, CHECK).
- done  out  1  last load succeeded.
- error  out  1  last load failed.
- loaded_count  out  ADDR_W+1  number of bytes written in current/last load.

Behaviour:
- Reset (asynchronous) clears the state and outputs:
  - state=IDLE.
  - s_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0.
  - cpu_reset=1.
  - busy=0, done=0, error=0, loaded_count=0.
- Transfer occurs on any cycle with s_valid && s_ready. No byte is consumed otherwise. s_valid gaps are allowed anywhere.
- s_ready=1 only in LEN, DATA and CHECK.
- States:
  - IDLE: on start -> LEN. Clear loaded_count, checksum accumulator, done and error.
  - LEN: on transfer, latch remaining=s_data.
    - s_data==0 or s_data>DEPTH -> ERROR.
    - Otherwise -> DATA.
  - DATA: on transfer:
    - Register wr_en=1, wr_addr=BASE_ADDR+loaded_count, wr_data=s_data. The write is visible on the cycle after acceptance; latency is 1.
    - Update the accumulator: acc ^= s_data.
    - loaded_count++, remaining--.
    - When remaining reaches 0 on this transfer -> CHECK.
  - CHECK: on transfer, compare s_data with acc.
    - Equal -> DONE.
    - Not equal -> ERROR.
  - DONE: done=1, cpu_reset=0. On start -> LEN, with cpu_reset=1 again from the next cycle.
  - ERROR: error=1, cpu_reset=1. On start -> LEN.
- wr_en is a single-cycle pulse per accepted data byte; it is 0 in all other cycles.
- Length and checksum bytes are never written to memory.
- wr_addr wraps modulo 2^ADDR_W. With the length limit to DEPTH, no wrap occurs within a legal load.
- start during LEN, DATA or CHECK is ignored. The load continues unaffected.
- cpu_reset=1 in every state except DONE. It is registered and glitch-free.
- busy is registered, 1 in LEN, DATA and CHECK.
- Asynchronous reset mid-load:
  - Aborts immediately to IDLE with the reset values above.
  - Memory contents already written are left as-is.
  - done stays 0 until a full successful load.
- Simultaneous start and a transfer in DONE/ERROR: s_ready=0 there, so no byte is consumed. Only start acts.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN, DATA, CHECK, DONE, ERROR);
  - the DATA_W/ADDR_W defaults;
  - a constant CKSUM_INIT=0.
- One natural sub-module, loader_write_port: the registered wr_en/wr_addr/wr_data stage and the address counter.
- The FSM, length counter and checksum stay in the top block.

Test Plan:
- Normal load: start; stream 0x03, 0x41, 0x82, 0xC7, checksum 0x04, s_valid held high.
  - Writes (0,0x41), (1,0x82), (2,0xC7), one per cycle, each one cycle after acceptance.
  - done=1, cpu_reset=0, loaded_count=3.
- Checksum mismatch: same stream with final byte 0x05.
  - Three writes still occur.
  - error=1, done=0, cpu_reset stays 1.
- Zero length: start; stream 0x00.
  - Next cycle error=1, no wr_en pulse, s_ready=0.
- Backpressure: stream 0x02, 0x10, 0x20, 0x30 with s_valid low for 3 cycles between every byte.
  - Exactly 2 writes, (0,0x10) and (1,0x20).
  - No write during gaps; done=1.
- Reset mid-load: assert reset after the second data byte of a length-4 load.
  - Immediately state IDLE, cpu_reset=1, loaded_count=0, busy=0, wr_en=0.
  - A later start with a fresh stream loads from address 0.
- Restart from DONE: after the normal load, pulse start; stream 0x01, 0x99, 0x99.
  - cpu_reset=1 during the load.
  - Write (0,0x99), then done=1 and cpu_reset=0.
  - A start pulse issued mid-stream is ignored.
